// File: rtl/fhe_poly_seq.sv
// fhe_poly_seq: multi-beat RNS polynomial sequencer for ciphertext arithmetic.
// Holds NREG polynomial registers of NPRIMES*NCOEF coefficients and runs one
// ciphertext instruction at a time, LANES coefficients per beat, through a
// read -> execute/writeback pipeline with two modular datapaths (d0, d1).
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   in_valid/in_ready          instruction handshake
//   in_op                      0=CT_CT_ADD 1=CT_PT_ADD 2=CT_PT_MUL 3=CT_CT_SUB
//   in_src0..3, in_dst0..1     source / destination register indices
//   busy                       instruction in flight (RUN or DRAIN)
//   done                       one-cycle pulse once all writes are committed
//   host_we/reg/elem/wdata     host write (IDLE or DONE only)
//   host_rdata                 registered read of [host_reg][host_elem]

// One lane of both modular datapaths.
module fhe_poly_lane #(
  parameter int W = 32
) (
  input  logic [1:0]   op,
  input  logic [W-1:0] q,
  input  logic [W-1:0] s0,
  input  logic [W-1:0] s1,
  input  logic [W-1:0] s2,
  input  logic [W-1:0] s3,
  output logic [W-1:0] d0,
  output logic [W-1:0] d1
);
  function automatic logic [W-1:0] mod_add(input logic [W-1:0] a, b, m);
    logic [W:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, m}) s = s - {1'b0, m};
    return s[W-1:0];
  endfunction

  // a + m - b may wrap through 2^W, but the true result is < m so the
  // truncated W-bit value is exact.
  function automatic logic [W-1:0] mod_sub(input logic [W-1:0] a, b, m);
    return (a < b) ? (a + m - b) : (a - b);
  endfunction

  function automatic logic [W-1:0] mod_mul(input logic [W-1:0] a, b, m);
    logic [2*W-1:0] prod;
    prod = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    return W'(prod % {{W{1'b0}}, m});
  endfunction

  always_comb begin
    d0 = '0;
    d1 = '0;
    case (op)
      2'd0: begin d0 = mod_add(s0, s2, q); d1 = mod_add(s1, s3, q); end
      2'd1: begin d0 = s0;                 d1 = mod_add(s1, s2, q); end
      2'd2: begin d0 = mod_mul(s0, s2, q); d1 = mod_mul(s1, s2, q); end
      default: begin d0 = mod_sub(s0, s2, q); d1 = mod_sub(s1, s3, q); end
    endcase
  end
endmodule

module fhe_poly_seq #(
  parameter int NREG    = 8,
  parameter int NPRIMES = 2,
  parameter int NCOEF   = 16,
  parameter int LANES   = 4,
  parameter int W       = 32,
  parameter logic [NPRIMES*W-1:0] Q_LIST = {32'd257, 32'd97}
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [1:0]                        in_op,
  input  logic [$clog2(NREG)-1:0]           in_src0,
  input  logic [$clog2(NREG)-1:0]           in_src1,
  input  logic [$clog2(NREG)-1:0]           in_src2,
  input  logic [$clog2(NREG)-1:0]           in_src3,
  input  logic [$clog2(NREG)-1:0]           in_dst0,
  input  logic [$clog2(NREG)-1:0]           in_dst1,
  output logic                              busy,
  output logic                              done,
  input  logic                              host_we,
  input  logic [$clog2(NREG)-1:0]           host_reg,
  input  logic [$clog2(NPRIMES*NCOEF)-1:0]  host_elem,
  input  logic [W-1:0]                      host_wdata,
  output logic [W-1:0]                      host_rdata
);
  localparam int NELEM = NPRIMES * NCOEF;
  localparam int BEATS = NELEM / LANES;
  localparam int RW    = $clog2(NREG);
  localparam int EW    = $clog2(NELEM);
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int PW    = (NPRIMES > 1) ? $clog2(NPRIMES) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t                          state, state_nxt;
  logic                            accept;
  logic [BW-1:0]                   beat;
  logic [1:0]                      op;
  logic [3:0][RW-1:0]              src;
  logic [1:0][RW-1:0]              dst;
  logic [W-1:0]                    rf [NREG][NELEM];

  logic                            ex_vld;
  logic [BW-1:0]                   ex_beat;
  logic [3:0][LANES-1:0][W-1:0]    opnd;
  logic [LANES-1:0][W-1:0]         res0, res1;
  logic [EW-1:0]                   rd_base, ex_base;
  logic [PW-1:0]                   ex_prime;
  logic [W-1:0]                    q_tab [NPRIMES];
  logic [W-1:0]                    q_sel;

  assign accept = in_valid & in_ready;

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (beat == BW'(BEATS - 1)) state_nxt = DRAIN;
      end
      DRAIN: begin
        busy      = 1'b1;
        state_nxt = DONE;
      end
      DONE: begin
        in_ready  = 1'b1;
        done      = 1'b1;
        state_nxt = in_valid ? RUN : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------- control / latches ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      beat       <= '0;
      ex_vld     <= 1'b0;
      ex_beat    <= '0;
      op         <= '0;
      src        <= '0;
      dst        <= '0;
      host_rdata <= '0;
    end else begin
      host_rdata <= rf[host_reg][host_elem];
      ex_vld     <= (state == RUN);
      ex_beat    <= beat;
      if (accept) begin
        op   <= in_op;
        src  <= {in_src3, in_src2, in_src1, in_src0};
        dst  <= {in_dst1, in_dst0};
        beat <= '0;
      end else if (state == RUN) begin
        beat <= beat + 1'b1;
      end
    end
  end

  // ---------------- read stage ----------------
  assign rd_base = EW'(int'(beat) * LANES);

  always_ff @(posedge clk) begin
    if (state == RUN)
      for (int i = 0; i < 4; i++)
        for (int l = 0; l < LANES; l++)
          opnd[i][l] <= rf[src[i]][rd_base + EW'(l)];
  end

  // ---------------- execute stage ----------------
  // A beat never straddles primes because NCOEF is a multiple of LANES.
  assign ex_base  = EW'(int'(ex_beat) * LANES);
  assign ex_prime = PW'(int'(ex_base) / NCOEF);

  for (genvar p = 0; p < NPRIMES; p++) begin : g_q
    assign q_tab[p] = Q_LIST[p*W +: W];
  end
  assign q_sel = q_tab[ex_prime];

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    fhe_poly_lane #(.W(W)) u_lane (
      .op (op),
      .q  (q_sel),
      .s0 (opnd[0][l]),
      .s1 (opnd[1][l]),
      .s2 (opnd[2][l]),
      .s3 (opnd[3][l]),
      .d0 (res0[l]),
      .d1 (res1[l])
    );
  end

  // ---------------- register file writes ----------------
  // Host writes only land in IDLE/DONE, when the pipeline is empty, so they
  // never collide with beat writeback. The d1 write comes last so it wins
  // when dst0 == dst1.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (host_we && in_ready)
        rf[host_reg][host_elem] <= host_wdata;
      if (ex_vld)
        for (int l = 0; l < LANES; l++) begin
          rf[dst[0]][ex_base + EW'(l)] <= res0[l];
          rf[dst[1]][ex_base + EW'(l)] <= res1[l];
        end
    end
  end
endmodule

// File: tb/tb_fhe_poly_seq.sv
// tb_fhe_poly_seq: directed bench for fhe_poly_seq with hand-computed
// expected register contents and handshake timing.
module tb_fhe_poly_seq;
  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  in_op = '0;
  logic [2:0]  in_src0 = '0, in_src1 = '0, in_src2 = '0, in_src3 = '0;
  logic [2:0]  in_dst0 = '0, in_dst1 = '0;
  logic        busy, done;
  logic        host_we = 1'b0;
  logic [2:0]  host_reg = '0;
  logic [4:0]  host_elem = '0;
  logic [31:0] host_wdata = '0;
  logic [31:0] host_rdata;

  int checks = 0;
  int failures = 0;
  logic [31:0] rb [32];

  fhe_poly_seq dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_src0(in_src0), .in_src1(in_src1), .in_src2(in_src2), .in_src3(in_src3),
    .in_dst0(in_dst0), .in_dst1(in_dst1),
    .busy(busy), .done(done),
    .host_we(host_we), .host_reg(host_reg), .host_elem(host_elem),
    .host_wdata(host_wdata), .host_rdata(host_rdata)
  );

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic host_wr(input int r, input int e, input logic [31:0] d);
    host_we = 1'b1; host_reg = 3'(r); host_elem = 5'(e); host_wdata = d;
    step();
    host_we = 1'b0;
  endtask

  task automatic dump(input int r);
    host_reg = 3'(r);
    for (int e = 0; e < 32; e++) begin
      host_elem = 5'(e);
      step();
      rb[e] = host_rdata;
    end
  endtask

  task automatic drive(input int o, input int a, b, c, d, x, y);
    in_op = 2'(o);
    in_src0 = 3'(a); in_src1 = 3'(b); in_src2 = 3'(c); in_src3 = 3'(d);
    in_dst0 = 3'(x); in_dst1 = 3'(y);
  endtask

  // Presents one instruction in cycle 0; returns in cycle 1.
  task automatic issue(input int o, input int a, b, c, d, x, y);
    drive(o, a, b, c, d, x, y);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  // Returns the cycle at which done is seen, or -1 on timeout.
  task automatic wait_done(input int start, output int cyc);
    cyc = start;
    while (done !== 1'b1 && cyc < start + 40) begin
      step();
      cyc++;
    end
    if (done !== 1'b1) cyc = -1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(); step();
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || host_rdata !== 32'd0) begin
      $display("FAIL reset_state got ready=%b busy=%b done=%b rdata=%0d exp 1 0 0 0",
               in_ready, busy, done, host_rdata);
      failures++;
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_ct_ct_add();
    int cyc;
    for (int e = 0; e < 32; e++) begin
      host_wr(0, e, 32'd90); host_wr(2, e, 32'd10);
      host_wr(1, e, 32'(e)); host_wr(3, e, 32'd1);
    end
    issue(0, 0, 1, 2, 3, 4, 5);
    wait_done(1, cyc);
    checks++;
    if (cyc !== 10) begin
      $display("FAIL add_done_cycle got=%0d exp=10", cyc); failures++;
    end
    step();
    checks++;
    if (done !== 1'b0 || in_ready !== 1'b1) begin
      $display("FAIL add_done_pulse got done=%b ready=%b exp 0 1", done, in_ready); failures++;
    end
    dump(4);
    for (int e = 0; e < 32; e++) begin
      checks++;
      if (rb[e] !== ((e < 16) ? 32'd3 : 32'd100)) begin
        $display("FAIL add_r4[%0d] got=%0d exp=%0d", e, rb[e], (e < 16) ? 3 : 100); failures++;
      end
    end
    dump(5);
    for (int e = 0; e < 32; e++) begin
      checks++;
      if (rb[e] !== 32'(e + 1)) begin
        $display("FAIL add_r5[%0d] got=%0d exp=%0d", e, rb[e], e + 1); failures++;
      end
    end
  endtask

  task automatic test_ct_pt_mul();
    int cyc;
    for (int e = 0; e < 32; e++) begin
      host_wr(0, e, 32'd96); host_wr(1, e, 32'd2); host_wr(2, e, 32'd96);
    end
    issue(2, 0, 1, 2, 3, 6, 7);
    wait_done(1, cyc);
    checks++;
    if (cyc !== 10) begin
      $display("FAIL mul_done_cycle got=%0d exp=10", cyc); failures++;
    end
    dump(6);
    for (int e = 0; e < 32; e++) begin
      checks++;
      if (rb[e] !== ((e < 16) ? 32'd1 : 32'd221)) begin
        $display("FAIL mul_r6[%0d] got=%0d exp=%0d", e, rb[e], (e < 16) ? 1 : 221); failures++;
      end
    end
    dump(7);
    for (int e = 0; e < 32; e++) begin
      checks++;
      if (rb[e] !== ((e < 16) ? 32'd95 : 32'd192)) begin
        $display("FAIL mul_r7[%0d] got=%0d exp=%0d", e, rb[e], (e < 16) ? 95 : 192); failures++;
      end
    end
  endtask

  // r0 = r0 - r2 in place; r1 = r1 - r3 in place (2 - 1).
  task automatic test_ct_ct_sub_inplace();
    int cyc;
    for (int e = 0; e < 32; e++) begin
      host_wr(0, e, 32'd5); host_wr(2, e, 32'd7);
    end
    issue(3, 0, 1, 2, 3, 0, 1);
    wait_done(1, cyc);
    checks++;
    if (cyc !== 10) begin
      $display("FAIL sub_done_cycle got=%0d exp=10", cyc); failures++;
    end
    dump(0);
    for (int e = 0; e < 32; e++) begin
      checks++;
      if (rb[e] !== ((e < 16) ? 32'd95 : 32'd255)) begin
        $display("FAIL sub_r0[%0d] got=%0d exp=%0d", e, rb[e], (e < 16) ? 95 : 255); failures++;
      end
    end
    dump(1);
    for (int e = 0; e < 32; e++) begin
      checks++;
      if (rb[e] !== 32'd1) begin
        $display("FAIL sub_r1[%0d] got=%0d exp=1", e, rb[e]); failures++;
      end
    end
  endtask

  // A: r6=r2+r2=14, r7=r3+r3=2. B (held during A): r4=r6-r3=13, r5=r7-r3=1.
  task automatic test_back_to_back();
    int cyc;
    int stall_bad;
    drive(0, 2, 3, 2, 3, 6, 7);
    in_valid = 1'b1;
    step();
    drive(3, 6, 7, 3, 3, 4, 5);
    stall_bad = 0;
    cyc = 1;
    while (cyc < 10) begin
      if (in_ready !== 1'b0 || busy !== 1'b1) stall_bad++;
      step();
      cyc++;
    end
    checks++;
    if (stall_bad != 0) begin
      $display("FAIL b2b_stall got=%0d bad cycles exp=0", stall_bad); failures++;
    end
    checks++;
    if (in_ready !== 1'b1 || done !== 1'b1) begin
      $display("FAIL b2b_cycle10 got ready=%b done=%b exp 1 1", in_ready, done); failures++;
    end
    step();
    in_valid = 1'b0;
    wait_done(11, cyc);
    checks++;
    if (cyc !== 20) begin
      $display("FAIL b2b_done_cycle got=%0d exp=20", cyc); failures++;
    end
    dump(6);
    for (int e = 0; e < 32; e++) begin
      checks++;
      if (rb[e] !== 32'd14) begin
        $display("FAIL b2b_r6[%0d] got=%0d exp=14", e, rb[e]); failures++;
      end
    end
    dump(4);
    for (int e = 0; e < 32; e++) begin
      checks++;
      if (rb[e] !== 32'd13) begin
        $display("FAIL b2b_r4[%0d] got=%0d exp=13", e, rb[e]); failures++;
      end
    end
    dump(5);
    for (int e = 0; e < 32; e++) begin
      checks++;
      if (rb[e] !== 32'd1) begin
        $display("FAIL b2b_r5[%0d] got=%0d exp=1", e, rb[e]); failures++;
      end
    end
  endtask

  // r4 = r2+r2 = 14, r5 = r3+r3 = 2, cut by reset in cycle 5: beats 0-2 only.
  task automatic test_reset_mid();
    int pulses;
    issue(0, 2, 3, 2, 3, 4, 5);
    repeat (4) step();
    reset = 1'b1;
    step();
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      $display("FAIL rstmid_cycle6 got ready=%b busy=%b done=%b exp 1 0 0",
               in_ready, busy, done);
      failures++;
    end
    reset = 1'b0;
    pulses = 0;
    repeat (12) begin
      step();
      if (done !== 1'b0 || busy !== 1'b0) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      $display("FAIL rstmid_no_done got=%0d active cycles exp=0", pulses); failures++;
    end
    dump(4);
    for (int e = 0; e < 32; e++) begin
      checks++;
      if (rb[e] !== ((e < 12) ? 32'd14 : 32'd13)) begin
        $display("FAIL rstmid_r4[%0d] got=%0d exp=%0d", e, rb[e], (e < 12) ? 14 : 13); failures++;
      end
    end
    dump(5);
    for (int e = 0; e < 32; e++) begin
      checks++;
      if (rb[e] !== ((e < 12) ? 32'd2 : 32'd1)) begin
        $display("FAIL rstmid_r5[%0d] got=%0d exp=%0d", e, rb[e], (e < 12) ? 2 : 1); failures++;
      end
    end
  endtask

  // CT_PT_ADD with dst0 == dst1 == 3: r3 = r5 + r4. A host write to r5[0]
  // in the accept cycle must be seen; a host write to r2[0] while busy is
  // dropped.
  task automatic test_alias_host_busy();
    int cyc;
    int exp;
    drive(1, 0, 5, 4, 0, 3, 3);
    in_valid = 1'b1;
    host_we = 1'b1; host_reg = 3'd5; host_elem = 5'd0; host_wdata = 32'd50;
    step();
    in_valid = 1'b0;
    host_we = 1'b0;
    checks++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin
      $display("FAIL alias_busy got busy=%b ready=%b exp 1 0", busy, in_ready); failures++;
    end
    step(); step();
    host_we = 1'b1; host_reg = 3'd2; host_elem = 5'd0; host_wdata = 32'd99;
    step();
    host_we = 1'b0;
    wait_done(4, cyc);
    checks++;
    if (cyc !== 10) begin
      $display("FAIL alias_done_cycle got=%0d exp=10", cyc); failures++;
    end
    step();
    dump(3);
    for (int e = 0; e < 32; e++) begin
      exp = (e == 0) ? 64 : ((e < 12) ? 16 : 14);
      checks++;
      if (rb[e] !== 32'(exp)) begin
        $display("FAIL alias_r3[%0d] got=%0d exp=%0d", e, rb[e], exp); failures++;
      end
    end
    dump(2);
    checks++;
    if (rb[0] !== 32'd7) begin
      $display("FAIL busy_host_we_r2[0] got=%0d exp=7", rb[0]); failures++;
    end
  endtask

  initial begin
    test_reset();
    test_ct_ct_add();
    test_ct_pt_mul();
    test_ct_ct_sub_inplace();
    test_back_to_back();
    test_reset_mid();
    test_alias_host_busy();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
